// File: rtl/store.sv
// FP16 result store: packs {sign, exp, mant} into a registered word with a valid/ready output.
// Optional second (skid) slot enabled by defining STORE_SKID_EN.
module store (
  input  logic        clk,
  input  logic        rst,
  input  logic        sign,
  input  logic [4:0]  exp,
  input  logic [9:0]  mant,
  input  logic        valid,
  output logic [15:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
`ifdef STORE_SKID_EN
    ,
    SKID  = 2'd2
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WORD_W-1:0] word_c;
  logic              xfer_c;
  logic              load_data_c;
  logic              drop_c;

`ifdef STORE_SKID_EN
  logic [WORD_W-1:0] skid_q;
  logic              load_skid_c;
  logic              data_from_skid_c;
`endif

  assign word_c = {sign, exp, mant};
  assign xfer_c = data_valid & data_ready;

  // A transfer in the current cycle frees the slot it vacates.
`ifdef STORE_SKID_EN
  assign busy = (state_q == SKID) & ~data_ready;
`else
  assign busy = (state_q == FULL) & ~data_ready;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    load_data_c = 1'b0;
    drop_c      = 1'b0;
`ifdef STORE_SKID_EN
    load_skid_c      = 1'b0;
    data_from_skid_c = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (valid) begin
          load_data_c = 1'b1;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (xfer_c) begin
          if (valid) load_data_c = 1'b1;
          else       state_d     = EMPTY;
        end else if (valid) begin
`ifdef STORE_SKID_EN
          load_skid_c = 1'b1;
          state_d     = SKID;
`else
          drop_c = 1'b1;
`endif
        end
      end
`ifdef STORE_SKID_EN
      SKID: begin
        if (xfer_c) begin
          load_data_c      = 1'b1;
          data_from_skid_c = 1'b1;
          if (valid) load_skid_c = 1'b1;
          else       state_d     = FULL;
        end else if (valid) begin
          drop_c = 1'b1;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      data       <= WORD_W'(0);
      data_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef STORE_SKID_EN
      skid_q     <= WORD_W'(0);
`endif
    end else begin
      state_q    <= state_d;
      data_valid <= (state_d != EMPTY);
      if (drop_c) overflow <= 1'b1;
`ifdef STORE_SKID_EN
      if (load_data_c) data <= data_from_skid_c ? skid_q : word_c;
      if (load_skid_c) skid_q <= word_c;
`else
      if (load_data_c) data <= word_c;
`endif
    end
  end

endmodule

// File: tb/tb_store.sv
// Randomized and directed bench for store, checked against a FIFO-queue reference model.
module tb_store;

`ifdef STORE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sign;
  logic [4:0]  exp;
  logic [9:0]  mant;
  logic        valid;
  logic [15:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: ordered queue of undelivered words, bounded by CAP.
  logic [15:0] q[$];
  logic [15:0] m_data;
  logic        m_ovf;

  store dut (
    .clk        (clk),
    .rst        (rst),
    .sign       (sign),
    .exp        (exp),
    .mant       (mant),
    .valid      (valid),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [15:0] w, input logic rdy);
    logic full_blocked;
    if (r) begin
      q.delete();
      m_data = 16'h0000;
      m_ovf  = 1'b0;
    end else begin
      full_blocked = (q.size() == CAP) && !rdy;
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v) begin
        if (full_blocked) m_ovf = 1'b1;
        else              q.push_back(w);
      end
      if (q.size() > 0) m_data = q[0];
    end
  endtask

  // One clock cycle: drive at negedge, compare outputs, then advance the model at posedge.
  task automatic step(input logic r, input logic v, input logic [15:0] w, input logic rdy);
    @(negedge clk);
    rst = r;
    valid = v;
    {sign, exp, mant} = w;
    data_ready = rdy;
    #1;
    check("data_valid", 16'(data_valid), 16'(q.size() > 0));
    check("data", data, m_data);
    check("busy", 16'(busy), 16'((q.size() == CAP) && !rdy));
    check("overflow", 16'(overflow), 16'(m_ovf));
    @(posedge clk);
    model_edge(r, v, w, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, rdy);
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    data_ready = 1'b0;
    {sign, exp, mant} = 16'h0000;
    m_data = 16'h0000;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    model_edge(1'b1, 1'b0, 16'h0000, 1'b0);
    #1;
    check("reset_data", data, 16'h0000);
    check("reset_valid", 16'(data_valid), 16'h0);
    check("reset_ovf", 16'(overflow), 16'h0);

    // Single word, consumer always ready.
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h3C00, 1'b1);
    #1;
    check("first_word", data, 16'h3C00);
    idle(3, 1'b1);

    // Hold under back-pressure, then drain; data retained afterwards.
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'hC200, 1'b0);
    idle(5, 1'b0);
    idle(3, 1'b1);
    check("held_after_drain", data, 16'hC200);

    // Back-to-back stream with no bubbles.
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h3C00, 1'b1);
    step(1'b0, 1'b1, 16'h4000, 1'b1);
    step(1'b0, 1'b1, 16'h4200, 1'b1);
    idle(3, 1'b1);

    // Overfill under back-pressure.
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h3C00, 1'b0);
    step(1'b0, 1'b1, 16'h4000, 1'b0);
    step(1'b0, 1'b1, 16'h4200, 1'b0);
    #1;
    check("overfill_ovf", 16'(overflow), 16'h1);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Reset mid-hold together with valid, then normal delivery.
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 1'b1);
    #1;
    check("midreset_data", data, 16'h0000);
    check("midreset_valid", 16'(data_valid), 16'h0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h3C00, 1'b1);
    #1;
    check("post_reset_word", data, 16'h3C00);
    idle(2, 1'b1);

    // Randomized traffic with varying consumer throttling.
    for (int blk = 0; blk < 8; blk++) begin
      int ready_pct;
      int valid_pct;
      ready_pct = $urandom_range(10, 100);
      valid_pct = $urandom_range(20, 90);
      for (int i = 0; i < 100; i++) begin
        step(1'b0 || ($urandom_range(0, 149) == 0),
             ($urandom_range(1, 100) <= valid_pct),
             16'($urandom),
             ($urandom_range(1, 100) <= ready_pct));
      end
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
